// File: rtl/smg_multiplex_driver.sv
// -----------------------------------------------------------------------------
// smg_multiplex_driver
//
// Time-multiplexed seven-segment display driver. A packed hex value of DIGITS
// nibbles and one decimal point per digit are scanned onto a shared segment
// bus and a set of digit enables, one digit per slot of SCAN_DIV cycles. Each
// slot starts with GUARD cycles where every digit is off, so the segment
// pattern of the previous digit cannot ghost onto the next one.
//
// The value shown is a per-frame snapshot: it is captured at the end of each
// frame (and continuously while the driver is disabled). A frame in progress
// therefore always shows one coherent value.
//
// Parameters
//   DIGITS          number of digits (1..8)
//   SCAN_DIV        clock cycles per digit slot (>= 4)
//   GUARD           dark cycles at the start of each slot (1..SCAN_DIV-1)
//   SEG_ACTIVE_LOW  1: a lit segment/dp is driven 0
//   DIG_ACTIVE_LOW  1: a selected digit is driven 0
//
// Ports
//   CLK         system clock
//   RST         synchronous, active-high reset
//   Enable      1: scan, 0: display dark and counters held at 0
//   Blank_Lead  1: suppress leading zero digits (digit 0 always shown)
//   Number_Sig  hex value, nibble i drives digit i (digit 0 least significant)
//   Dp_Sig      decimal point per digit
//   SMG_Data    bit 7 = dp, bits 6..0 = segments g..a (registered)
//   Scan_Sig    one-hot digit select (registered)
//   Frame_Done  one-cycle pulse when the last slot of a frame ends
// -----------------------------------------------------------------------------
module smg_multiplex_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Enable,
  input  logic                  Blank_Lead,
  input  logic [4*DIGITS-1:0]   Number_Sig,
  input  logic [DIGITS-1:0]     Dp_Sig,
  output logic [7:0]            SMG_Data,
  output logic [DIGITS-1:0]     Scan_Sig,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Idle ("off") level of each output bus. XOR-ing an active-high pattern with
  // these masks yields the pin-level pattern for the selected polarity.
  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                : {DIGITS{1'b0}};

  // Hex digit to active-high segment pattern, bit 0 = segment a.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // State
  logic [CW-1:0]       cnt_q,  cnt_d;
  logic [IW-1:0]       idx_q,  idx_d;
  logic [4*DIGITS-1:0] num_q,  num_d;
  logic [DIGITS-1:0]   dp_q,   dp_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          smg_q,  smg_d;
  logic [DIGITS-1:0]   scan_q, scan_d;

  // Combinational helpers
  logic                end_of_slot_s;
  logic                end_of_frame_s;
  logic                load_s;
  logic [DIGITS-1:0]   zero_above_s;
  logic [3:0]          cur_nib_s;
  logic                blank_s;
  logic                lit_s;
  logic [6:0]          seg_s;
  logic [7:0]          smg_raw_s;
  logic [DIGITS-1:0]   scan_raw_s;

  // Slot/frame boundary detection.
  always_comb begin
    end_of_slot_s  = (cnt_q == CNT_LAST);
    end_of_frame_s = end_of_slot_s && (idx_q == IDX_LAST);
  end

  // Slot counter and digit index; both held at zero while disabled so that
  // scanning always resumes from digit 0 at the start of its guard interval.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!Enable) begin
      cnt_d = {CW{1'b0}};
      idx_d = {IW{1'b0}};
    end else if (end_of_slot_s) begin
      cnt_d = {CW{1'b0}};
      if (end_of_frame_s) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Snapshot capture at frame end (and continuously while disabled) plus the
  // frame-done pulse that marks the capture.
  always_comb begin
    load_s       = (!Enable) || end_of_frame_s;
    frame_done_d = Enable && end_of_frame_s;
    if (load_s) begin
      num_d = Number_Sig;
      dp_d  = Dp_Sig;
    end else begin
      num_d = num_q;
      dp_d  = dp_q;
    end
  end

  // zero_above_s[i] is set when snapshot nibbles i..DIGITS-1 are all zero,
  // i.e. digit i is a leading zero.
  always_comb begin
    logic all_zero_v;
    all_zero_v   = 1'b1;
    zero_above_s = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero_v      = all_zero_v && (num_q[4*i +: 4] == 4'h0);
      zero_above_s[i] = all_zero_v;
    end
  end

  // Pattern for the current slot, dark during the guard interval or when
  // disabled; the dp of a blanked digit still follows its snapshot bit.
  always_comb begin
    cur_nib_s  = num_q[4*idx_q +: 4];
    blank_s    = Blank_Lead && (idx_q != {IW{1'b0}}) && zero_above_s[idx_q];
    lit_s      = Enable && (cnt_q >= GUARD_CNT);
    seg_s      = seg_encode(cur_nib_s);
    smg_raw_s  = 8'h00;
    scan_raw_s = {DIGITS{1'b0}};
    if (lit_s) begin
      if (blank_s) begin
        smg_raw_s = {dp_q[idx_q], 7'h00};
      end else begin
        smg_raw_s = {dp_q[idx_q], seg_s};
      end
      for (int i = 0; i < DIGITS; i++) begin
        scan_raw_s[i] = (idx_q == IW'(i));
      end
    end else begin
      smg_raw_s  = 8'h00;
      scan_raw_s = {DIGITS{1'b0}};
    end
    smg_d  = smg_raw_s ^ SEG_OFF;
    scan_d = scan_raw_s ^ DIG_OFF;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= {CW{1'b0}};
      idx_q        <= {IW{1'b0}};
      num_q        <= {(4*DIGITS){1'b0}};
      dp_q         <= {DIGITS{1'b0}};
      frame_done_q <= 1'b0;
      smg_q        <= SEG_OFF;
      scan_q       <= DIG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      smg_q        <= smg_d;
      scan_q       <= scan_d;
    end
  end

  assign SMG_Data   = smg_q;
  assign Scan_Sig   = scan_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_smg_multiplex_driver.sv
// -----------------------------------------------------------------------------
// Testbench for smg_multiplex_driver (DIGITS=4, SCAN_DIV=8, GUARD=2, both
// polarities active-low). A reference model tracks elapsed scan time and the
// per-frame snapshot, pushes the expected outputs into a queue, and a separate
// monitor compares them with the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_smg_multiplex_driver;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int G  = 2;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        blank;
  logic [15:0] num;
  logic [3:0]  dp;
  logic [7:0]  smg;
  logic [3:0]  scan;
  logic        fd;

  always #5 clk = ~clk;

  smg_multiplex_driver #(
    .DIGITS         (D),
    .SCAN_DIV       (SD),
    .GUARD          (G),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .Enable     (en),
    .Blank_Lead (blank),
    .Number_Sig (num),
    .Dp_Sig     (dp),
    .SMG_Data   (smg),
    .Scan_Sig   (scan),
    .Frame_Done (fd)
  );

  typedef struct packed {
    logic [7:0] smg;
    logic [3:0] scan;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t pending;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: cycles since scanning (re)started, and the value
  // currently being displayed.
  int          m_t   = 0;
  logic [15:0] m_num = 16'h0000;
  logic [3:0]  m_dp  = 4'h0;

  // Expected outputs after the coming edge, given the inputs now applied.
  task automatic model_step();
    exp_t        e;
    int          pos;
    int          slot;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [3:0]  sel;
    logic [7:0]  b;
    e.smg  = 8'hFF;
    e.scan = 4'hF;
    e.fd   = 1'b0;
    if (rst) begin
      m_t = 0; m_num = 16'h0000; m_dp = 4'h0;
    end else if (!en) begin
      m_t = 0; m_num = num; m_dp = dp;
    end else begin
      pos   = m_t % SD;
      slot  = (m_t / SD) % D;
      upper = m_num >> (4 * slot);
      nib   = upper[3:0];
      if (pos >= G) begin
        b[6:0] = (blank && slot > 0 && upper == 16'h0000) ? 7'h00 : FONT[nib];
        b[7]   = m_dp[slot];
        sel    = 4'b0001 << slot;
        e.smg  = ~b;
        e.scan = ~sel;
      end
      if (pos == SD - 1 && slot == D - 1) begin
        e.fd  = 1'b1;
        m_num = num;
        m_dp  = dp;
      end
      m_t++;
    end
    pending = e;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    exp_q.push_back(pending);
  endtask

  // Advance until the next modelled cycle sits at the given slot/position.
  task automatic wait_slot(input int slot, input int pos);
    int n;
    n = 0;
    while (!(((m_t % SD) == pos) && (((m_t / SD) % D) == slot)) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) begin
      miscompares++;
      $display("FAIL wait_slot timeout slot=%0d pos=%0d got t=%0d", slot, pos, m_t);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({smg, scan, fd} !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: smg=%h exp %h, scan=%b exp %b, frame_done=%b exp %b",
                 $time, smg, e.smg, scan, e.scan, fd, e.fd);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    blank = 1'b0;
    num   = 16'h1234;
    dp    = 4'b0100;

    // Reset held for three cycles, then scan order over several frames.
    repeat (3) cycle();
    rst = 1'b0;
    repeat (3 * 32) cycle();

    // Leading-zero blanking.
    blank = 1'b1; num = 16'h0050; dp = 4'h0;
    repeat (2 * 32) cycle();
    num = 16'h0000;
    repeat (2 * 32) cycle();

    // Snapshot coherence: change value during slot 1.
    blank = 1'b0; num = 16'h1111;
    wait_slot(0, 0);
    repeat (32) cycle();
    wait_slot(1, 3);
    num = 16'h2222;
    repeat (2 * 32) cycle();

    // Enable dropped in slot 2, then restored.
    wait_slot(2, 4);
    en = 1'b0;
    repeat (3) cycle();
    en = 1'b1;
    repeat (40) cycle();

    // Reset in slot 3.
    wait_slot(3, 5);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (40) cycle();

    // Randomised operation.
    repeat (1500) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 49) != 0);
      blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        num = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
        dp  = 4'($urandom_range(0, 15));
      end
      cycle();
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
